// File: rtl/syn_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : syn_pipe_hazard_ctrl
// Brief    : Hazard and forwarding controller for the 5-stage core. Tracks the
//            destination registers of in-flight instructions and produces
//            per-operand forwarding selects, load-use stalls, branch flushes
//            and saturating stall/flush debug counters.
// Options  : PIPE_HAZARD_HALT_DRAIN_EN - builds the RUN/DRAIN/HALTED drain FSM
//            driven by halt_req; when undefined halt_req is ignored and
//            drained is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module syn_pipe_hazard_ctrl #(
  parameter int REG_ADDR_BIT = 5,
  parameter int FWD_DEPTH    = 2,
  parameter int LOAD_LAT     = 1,
  parameter int CNT_BIT      = 16,
  localparam int FWD_SEL_BIT = $clog2(FWD_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    id_valid,
  input  logic [REG_ADDR_BIT-1:0] id_req_a,
  input  logic [REG_ADDR_BIT-1:0] id_req_b,
  input  logic                    id_use_a,
  input  logic                    id_use_b,
  input  logic                    id_w_en,
  input  logic [REG_ADDR_BIT-1:0] id_req_w,
  input  logic                    id_is_load,
  input  logic                    ex_redirect,
  input  logic                    halt_req,
  output logic                    stall,
  output logic                    flush,
  output logic [FWD_SEL_BIT-1:0]  fwd_sel_a,
  output logic [FWD_SEL_BIT-1:0]  fwd_sel_b,
  output logic                    drained,
  output logic [CNT_BIT-1:0]      stall_cnt,
  output logic [CNT_BIT-1:0]      flush_cnt
);

  localparam logic [CNT_BIT-1:0] c_cnt_max = {CNT_BIT{1'b1}};

  // Scoreboard, entry 1 = instruction currently in EX
  logic [FWD_DEPTH:1]      r_sb_valid;
  logic [FWD_DEPTH:1]      r_sb_wen;
  logic [FWD_DEPTH:1]      r_sb_load;
  logic [REG_ADDR_BIT-1:0] r_sb_reg [1:FWD_DEPTH];

  logic [FWD_SEL_BIT-1:0]  w_sel_a;
  logic [FWD_SEL_BIT-1:0]  w_sel_b;
  logic                    w_lu_a;
  logic                    w_lu_b;
  logic                    w_drain_stall;

  // Youngest-match search: scanning oldest to youngest lets entry 1 win
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_lu_a  = 1'b0;
    w_lu_b  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (r_sb_valid[k] && r_sb_wen[k] && id_use_a && (id_req_a != '0) &&
          (r_sb_reg[k] == id_req_a)) begin
        w_sel_a = FWD_SEL_BIT'(k);
        w_lu_a  = r_sb_load[k] && (k <= LOAD_LAT);
      end
      if (r_sb_valid[k] && r_sb_wen[k] && id_use_b && (id_req_b != '0) &&
          (r_sb_reg[k] == id_req_b)) begin
        w_sel_b = FWD_SEL_BIT'(k);
        w_lu_b  = r_sb_load[k] && (k <= LOAD_LAT);
      end
    end
  end

  // A load result that is not yet available cannot be forwarded: read regfile
  assign fwd_sel_a = w_lu_a ? '0 : w_sel_a;
  assign fwd_sel_b = w_lu_b ? '0 : w_sel_b;

  // Redirect squashes the ID instruction, so a flush overrides any stall
  assign flush = ex_redirect;
  assign stall = (w_lu_a | w_lu_b | w_drain_stall) & ~ex_redirect;

  // Scoreboard shift: entry 1 takes the ID instruction or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_valid <= '0;
      r_sb_wen   <= '0;
      r_sb_load  <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        r_sb_reg[k] <= '0;
      end
    end else if (en) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        r_sb_valid[k] <= r_sb_valid[k-1];
        r_sb_wen[k]   <= r_sb_wen[k-1];
        r_sb_load[k]  <= r_sb_load[k-1];
        r_sb_reg[k]   <= r_sb_reg[k-1];
      end
      r_sb_valid[1] <= id_valid & ~stall & ~flush;
      r_sb_wen[1]   <= id_w_en;
      r_sb_load[1]  <= id_is_load;
      r_sb_reg[1]   <= id_req_w;
    end
  end

  // Saturating debug counters of stall and flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (en) begin
      if (stall && (stall_cnt != c_cnt_max)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != c_cnt_max)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

`ifdef PIPE_HAZARD_HALT_DRAIN_EN
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t r_state;
  logic   r_drained;
  logic   w_older_empty;

  // Entry 1 is bubbled while draining, so the pipe is empty after this edge
  // once every entry that shifts onward is already invalid
  always_comb begin
    w_older_empty = 1'b1;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      if (r_sb_valid[k]) w_older_empty = 1'b0;
    end
  end

  assign w_drain_stall = (r_state == ST_DRAIN) | halt_req;
  assign drained       = r_drained;

  // Drain FSM with registered drained flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_drained <= 1'b0;
    end else if (en) begin
      case (r_state)
        ST_RUN: begin
          if (halt_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_older_empty) begin
            r_state   <= ST_HALTED;
            r_drained <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end
`else
  logic w_unused_halt;

  assign w_unused_halt = halt_req;
  assign w_drain_stall = 1'b0;
  assign drained       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_syn_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_pipe_hazard_ctrl
// Brief    : Self-checking bench for syn_pipe_hazard_ctrl. A driver issues
//            directed and random ID/EX traffic, predicts each cycle's outputs
//            from a queue of in-flight instructions and queues them; a monitor
//            pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_pipe_hazard_ctrl;

  localparam int REG_ADDR_BIT = 5;
  localparam int FWD_DEPTH    = 2;
  localparam int LOAD_LAT     = 1;
  localparam int CNT_BIT      = 4;
  localparam int SEL_W        = $clog2(FWD_DEPTH + 1);
  localparam int CNT_MAX      = (1 << CNT_BIT) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic                    id_valid = 1'b0;
  logic [REG_ADDR_BIT-1:0] id_req_a = '0;
  logic [REG_ADDR_BIT-1:0] id_req_b = '0;
  logic                    id_use_a = 1'b0;
  logic                    id_use_b = 1'b0;
  logic                    id_w_en = 1'b0;
  logic [REG_ADDR_BIT-1:0] id_req_w = '0;
  logic                    id_is_load = 1'b0;
  logic                    ex_redirect = 1'b0;
  logic                    halt_req = 1'b0;
  logic                    stall;
  logic                    flush;
  logic [SEL_W-1:0]        fwd_sel_a;
  logic [SEL_W-1:0]        fwd_sel_b;
  logic                    drained;
  logic [CNT_BIT-1:0]      stall_cnt;
  logic [CNT_BIT-1:0]      flush_cnt;

  always #5 clk = ~clk;

  syn_pipe_hazard_ctrl #(
    .REG_ADDR_BIT (REG_ADDR_BIT),
    .FWD_DEPTH    (FWD_DEPTH),
    .LOAD_LAT     (LOAD_LAT),
    .CNT_BIT      (CNT_BIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .id_valid    (id_valid),
    .id_req_a    (id_req_a),
    .id_req_b    (id_req_b),
    .id_use_a    (id_use_a),
    .id_use_b    (id_use_b),
    .id_w_en     (id_w_en),
    .id_req_w    (id_req_w),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .halt_req    (halt_req),
    .stall       (stall),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .drained     (drained),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  typedef struct {
    bit       v;
    bit       wen;
    bit [4:0] w;
    bit       ld;
  } instr_t;

  typedef struct {
    bit stall;
    bit flush;
    int sel_a;
    int sel_b;
    int scnt;
    int fcnt;
  } exp_t;

  instr_t inflight[$];   // index 0 = youngest (in EX)
  exp_t   expq[$];
  int     m_scnt;
  int     m_fcnt;
  int     n_vec;
  int     n_bad;

  function automatic void model_reset();
    instr_t b;
    b = '{v: 1'b0, wen: 1'b0, w: 5'd0, ld: 1'b0};
    inflight.delete();
    for (int i = 0; i < FWD_DEPTH; i++) inflight.push_back(b);
    m_scnt = 0;
    m_fcnt = 0;
  endfunction

  // Youngest in-flight writer of r; a load still inside its latency blocks it
  function automatic void lookup(input bit [4:0] r, input bit use_r,
                                 output int sel, output bit lu);
    bit found;
    sel   = 0;
    lu    = 1'b0;
    found = 1'b0;
    if (use_r && (r != 5'd0)) begin
      for (int i = 0; i < inflight.size(); i++) begin
        if (!found && inflight[i].v && inflight[i].wen && (inflight[i].w == r)) begin
          found = 1'b1;
          sel   = i + 1;
          lu    = inflight[i].ld && ((i + 1) <= LOAD_LAT);
        end
      end
    end
    if (lu) sel = 0;
  endfunction

  task automatic step(input bit e, input bit v, input bit [4:0] a, input bit [4:0] b,
                      input bit ua, input bit ub, input bit we, input bit [4:0] w,
                      input bit ld, input bit rd, input bit rst);
    exp_t   x;
    instr_t ni;
    int     sa, sb;
    bit     la, lb;
    @(negedge clk);
    en = e; id_valid = v; id_req_a = a; id_req_b = b; id_use_a = ua; id_use_b = ub;
    id_w_en = we; id_req_w = w; id_is_load = ld; ex_redirect = rd; halt_req = 1'b0;
    if (rst) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
    end
    lookup(a, ua, sa, la);
    lookup(b, ub, sb, lb);
    x.flush = rd;
    x.stall = (la || lb) && !rd;
    x.sel_a = sa;
    x.sel_b = sb;
    x.scnt  = m_scnt;
    x.fcnt  = m_fcnt;
    expq.push_back(x);
    @(posedge clk);
    if (!rst && e) begin
      if (x.stall && m_scnt < CNT_MAX) m_scnt++;
      if (x.flush && m_fcnt < CNT_MAX) m_fcnt++;
      ni = '{v: v && !x.stall && !x.flush, wen: we, w: w, ld: ld};
      void'(inflight.pop_back());
      inflight.push_front(ni);
    end
  endtask

  function automatic void chk(input string name, input int act, input int req);
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: sample mid-cycle, well away from the rising edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() != 0) begin
        x = expq.pop_front();
        n_vec++;
        chk("stall", int'(stall), int'(x.stall));
        chk("flush", int'(flush), int'(x.flush));
        chk("fwd_sel_a", int'(fwd_sel_a), x.sel_a);
        chk("fwd_sel_b", int'(fwd_sel_b), x.sel_b);
        chk("stall_cnt", int'(stall_cnt), x.scnt);
        chk("flush_cnt", int'(flush_cnt), x.fcnt);
        chk("drained", int'(drained), 0);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add $3 ; add $4,$3,$5 -> forward from 1 ; bubble ; reader of $3 -> 2
    step(1, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
    step(1, 1, 3, 5, 1, 0, 1, 4, 0, 0, 0);
    step(1, 0, 3, 5, 1, 0, 0, 0, 0, 0, 0);
    // lw $3 ; add $4,$3,$3 stalls once then forwards from 2 on both
    step(1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    // two writers of $7 -> youngest; writer of $0 never forwards
    step(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // redirect coinciding with a load-use hit
    step(1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 1, 3, 0, 1, 0, 1, 4, 0, 1, 0);
    step(1, 1, 3, 0, 1, 0, 1, 4, 0, 0, 0);
    // pending load-use held across en=0
    step(1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    // reset asserted while a stall is pending releases it at once
    step(1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    step(1, 1, 3, 3, 1, 1, 1, 4, 0, 0, 1);
    // random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 5) != 0), ($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    #4;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
